bin_to_bcd_display: RTL



---
 rtl/bin_to_bcd_display.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_display.sv
// Purpose : converts the adder's {Cout, Sum} to BCD with a serial double-dabble engine
//           and drives active-low seven-segment displays.
// Latency : accept at E0, result and out_valid at EW, next accept no earlier than E(W+2).
// Backpr. : single-entry, no queue; in_ready is high only in IDLE and in_valid is
//           ignored while busy, so upstream must hold or drop its value.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready input handshake; Value is captured when both are high
//   Value [W-1:0]     unsigned binary input
//   out_valid         one-cycle pulse when bcd/HEX have just been updated
//   busy              conversion in progress; exact complement of in_ready
//   bcd [4*DIGITS-1:0] BCD result, digit 0 in [3:0]
//   HEX [7*DIGITS-1:0] segments g..a, active-low, digit 0 in [6:0]
//
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits above
// digit 0. bcd, the handshake and the latency are the same in both builds.
// Parameter constraint: 2**W - 1 < 10**DIGITS, and W >= 2.

module bin_to_bcd_display #(
    parameter int W      = 5,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          Value,
    output logic                  out_valid,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   HEX
);

    localparam int CNT_W = $clog2(W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Active-low segment pattern, bit order g f e d c b a.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Display pattern for an all-zero bcd value, used as the reset image.
    function automatic logic [7*DIGITS-1:0] hex_reset_val();
        logic [7*DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
            r[7*i +: 7] = (i != 0) ? 7'h7F : 7'h40;
`else
            r[7*i +: 7] = 7'h40;
`endif
        end
        return r;
    endfunction

    localparam logic [7*DIGITS-1:0] HEX_RST = hex_reset_val();

    // State and datapath flops
    state_t                state_q,     state_d;
    logic [W-1:0]          shift_q,     shift_d;
    logic [4*DIGITS-1:0]   scratch_q,   scratch_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic                  in_ready_q,  in_ready_d;
    logic                  busy_q,      busy_d;
    logic                  out_valid_q, out_valid_d;
    logic [4*DIGITS-1:0]   bcd_q,       bcd_d;
    logic [7*DIGITS-1:0]   hex_q,       hex_d;

    // One double-dabble step: add-3 correction on every nibble, then shift.
    logic [4*DIGITS-1:0]   adj;
    logic [4*DIGITS-1:0]   step_scratch;
    logic [W-1:0]          step_shift;

    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? (scratch_q[4*i +: 4] + 4'd3)
                                                          :  scratch_q[4*i +: 4];
        end
        step_scratch = {adj[4*DIGITS-2:0], shift_q[W-1]};
        step_shift   = {shift_q[W-2:0], 1'b0};
    end

    // Segment image of the value produced by the final step. It is computed from
    // step_scratch (not bcd_q) so that HEX updates on the same edge as bcd.
    logic [7*DIGITS-1:0]   hex_new;
`ifdef LEADING_ZERO_BLANK_EN
    logic                  zero_above;

    always_comb begin
        hex_new    = '0;
        zero_above = 1'b1;
        // Walk from the most significant digit down; a digit is blanked only
        // while it and everything above it are zero. Digit 0 always shows.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (step_scratch[4*i +: 4] == 4'd0);
            hex_new[7*i +: 7] = ((i != 0) && zero_above) ? 7'h7F
                                                         : seg7(step_scratch[4*i +: 4]);
        end
    end
`else
    always_comb begin
        hex_new = '0;
        for (int i = 0; i < DIGITS; i++) begin
            hex_new[7*i +: 7] = seg7(step_scratch[4*i +: 4]);
        end
    end
`endif

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        out_valid_d = 1'b0;
        bcd_d       = bcd_q;
        hex_d       = hex_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shift_d    = Value;
                    scratch_d  = '0;
                    cnt_d      = '0;
                    state_d    = ST_SHIFT;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                scratch_d = step_scratch;
                shift_d   = step_shift;
                cnt_d     = cnt_q + CNT_W'(1);
                // Last step: publish the result on the same edge it is formed.
                if (cnt_q == CNT_W'(W - 1)) begin
                    state_d     = ST_DONE;
                    bcd_d       = step_scratch;
                    hex_d       = hex_new;
                    out_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                in_ready_d = 1'b1;
            end
            default: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                in_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            bcd_q       <= '0;
            hex_q       <= HEX_RST;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            scratch_q   <= scratch_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            bcd_q       <= bcd_d;
            hex_q       <= hex_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign bcd       = bcd_q;
    assign HEX       = hex_q;

endmodule
